// File: rtl/clk_counter_pkg.sv
// Shared types and defaults for the start/stop run-length statistics block.
package clk_counter_pkg;

    // Default widths: counter/run length, saturating sum, saturating run count
    localparam int CNT_W_DEF  = 32;
    localparam int SUM_W_DEF  = 48;
    localparam int NRUN_W_DEF = 16;

    // Fill bits for the min/max trackers; min starts at all-ones so the
    // first run always replaces it, max starts at zero for the same reason.
    localparam logic STAT_MIN_RST_BIT = 1'b1;
    localparam logic STAT_MAX_RST_BIT = 1'b0;

    // Run-tracking FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_EMIT   = 2'd3
    } state_e;

endpackage

// File: rtl/cycle_stats_acc.sv
// Running min / max / saturating sum / saturating count of run lengths.
module cycle_stats_acc
    import clk_counter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SUM_W  = SUM_W_DEF,
    parameter int NRUN_W = NRUN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              upd,
    input  logic [CNT_W-1:0]  len,
    output logic [CNT_W-1:0]  stat_min,
    output logic [CNT_W-1:0]  stat_max,
    output logic [SUM_W-1:0]  stat_sum,
    output logic [NRUN_W-1:0] stat_nruns
);

    logic [CNT_W-1:0]  min_q, min_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [NRUN_W-1:0] nruns_q, nruns_d;
    // One extra bit so the carry out of the sum reveals overflow
    logic [SUM_W:0]    sum_ext;

    // Next-value logic: clear wins over an update in the same cycle
    always_comb begin
        sum_ext = {1'b0, sum_q} + (SUM_W+1)'(len);
        min_d   = min_q;
        max_d   = max_q;
        sum_d   = sum_q;
        nruns_d = nruns_q;
        if (clear) begin
            min_d   = {CNT_W{STAT_MIN_RST_BIT}};
            max_d   = {CNT_W{STAT_MAX_RST_BIT}};
            sum_d   = '0;
            nruns_d = '0;
        end else if (upd) begin
            if (len < min_q) min_d = len;
            if (len > max_q) max_d = len;
            sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            if (nruns_q != {NRUN_W{1'b1}}) nruns_d = nruns_q + NRUN_W'(1);
        end
    end

    // Statistic registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q   <= {CNT_W{STAT_MIN_RST_BIT}};
            max_q   <= {CNT_W{STAT_MAX_RST_BIT}};
            sum_q   <= '0;
            nruns_q <= '0;
        end else begin
            min_q   <= min_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            nruns_q <= nruns_d;
        end
    end

    assign stat_min   = min_q;
    assign stat_max   = max_q;
    assign stat_sum   = sum_q;
    assign stat_nruns = nruns_q;

endmodule

// File: rtl/clk_counter_stats.sv
// Turns start/stop strobes plus a free-running cycle counter into run
// lengths, publishes each on a valid/ready port and keeps statistics.
module clk_counter_stats
    import clk_counter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SUM_W  = SUM_W_DEF,
    parameter int NRUN_W = NRUN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              clear,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_len,
    output logic [CNT_W-1:0]  stat_min,
    output logic [CNT_W-1:0]  stat_max,
    output logic [SUM_W-1:0]  stat_sum,
    output logic [NRUN_W-1:0] stat_nruns,
    output logic              missed,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]  res_len_q, res_len_d;
    logic              missed_q, missed_d;
    logic [CNT_W-1:0]  len;
    logic              upd;

    // Modulo subtraction makes a counter wrap during the run transparent
    assign len = cnt_i - base_q;

    // State register; reset abandons any partial run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start+stop together in IDLE is not a run because
    // the counter itself stays stopped in that case
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start && !stop) state_d = ST_RUN;
                ST_RUN:    if (stop)           state_d = ST_SETTLE;
                ST_SETTLE:                     state_d = ST_EMIT;
                ST_EMIT:   if (res_ready)      state_d = ST_IDLE;
                default:                       state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: base capture, result load, sticky missed flag
    always_comb begin
        base_d    = base_q;
        res_len_d = res_len_q;
        missed_d  = missed_q;
        if (clear) begin
            base_d    = '0;
            res_len_d = '0;
            missed_d  = 1'b0;
        end else begin
            if (state_q == ST_IDLE && start && !stop) base_d = cnt_i;
            if (state_q == ST_SETTLE)                 res_len_d = len;
            if ((state_q == ST_SETTLE || state_q == ST_EMIT) && start)
                missed_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            res_len_q <= '0;
            missed_q  <= 1'b0;
        end else begin
            base_q    <= base_d;
            res_len_q <= res_len_d;
            missed_q  <= missed_d;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        res_valid = (state_q == ST_EMIT);
        busy      = (state_q != ST_IDLE);
        upd       = (state_q == ST_SETTLE) && !clear;
    end

    assign res_len = res_len_q;
    assign missed  = missed_q;

    cycle_stats_acc #(
        .CNT_W  (CNT_W),
        .SUM_W  (SUM_W),
        .NRUN_W (NRUN_W)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .upd        (upd),
        .len        (len),
        .stat_min   (stat_min),
        .stat_max   (stat_max),
        .stat_sum   (stat_sum),
        .stat_nruns (stat_nruns)
    );

endmodule

// File: doc/clk_counter_stats.md
# clk_counter_stats

Downstream consumer of the free-running start/stop cycle counter in the InputDTC latency-measurement path. Watches the same `start`/`stop` strobes that drive the counter and samples its 32-bit count value. Turns the count into per-run lengths, and publishes each length on a valid/ready result port. Keeps running minimum, maximum, sum and run count for debug readout.

## Interface
- `CNT_W`, 32: width of counter input and run length
- `SUM_W`, 48: width of saturating sum accumulator
- `NRUN_W`, 16: width of saturating run counter

- `clk`  in  1  single clock domain, shared with the counter
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  run-start strobe, same net as the counter's start
- `stop`  in  1  run-stop strobe, same net as the counter's stop
- `cnt_i`  in  CNT_W  counter output value
- `clear`  in  1  synchronous clear of statistics and FSM
- `res_valid`  out  1  result record valid
- `res_ready`  in  1  downstream accepts record
- `res_len`  out  CNT_W  length of last completed run, in cycles
- `stat_min`  out  CNT_W  minimum run length since clear
- `stat_max`  out  CNT_W  maximum run length since clear
- `stat_sum`  out  SUM_W  saturating sum of run lengths
- `stat_nruns`  out  NRUN_W  saturating count of completed runs
- `missed`  out  1  sticky: a start arrived while not IDLE
- `busy`  out  1  FSM not IDLE

## Operation
- FSM states: IDLE, RUN, SETTLE, EMIT.
- **IDLE**
  - `start`=1 and `stop`=0: latch `base <= cnt_i` and go to RUN.
  - `start`=1 and `stop`=1: ignored, because the counter also stays stopped.
  - `stop` alone: ignored.
- **RUN**
  - `stop`=1, with any value of `start`: go to SETTLE.
  - `start` alone: ignored, not flagged.
- **SETTLE** (exactly one cycle)
  - Compute `len = cnt_i - base`, modulo 2^CNT_W. Wrap of the counter is therefore transparent.
  - Load `res_len`, update statistics, then go to EMIT.
- **EMIT**
  - `res_valid`=1.
  - Go to IDLE on the cycle where `res_ready`=1.
- A `start` seen in SETTLE or EMIT sets `missed` and is otherwise dropped. The counter still runs in that case; the next accepted run's base is taken fresh.
- **Statistics**, updated in SETTLE:
  - `stat_min` = min(`stat_min`, `len`).
  - `stat_max` = max(`stat_max`, `len`).
  - `stat_sum` += zero-extended `len`, saturating at all-ones.
  - `stat_nruns` += 1, saturating at all-ones.
- **`clear`**
  - Highest priority after `rst`.
  - Forces IDLE and `res_valid`=0.
  - Returns every statistic, `res_len`, `base` and `missed` to its reset value.

## Timing
- **Reset values:**
  - `res_valid`=0, `res_len`=0.
  - `stat_min`=all-ones, `stat_max`=0, `stat_sum`=0, `stat_nruns`=0.
  - `missed`=0, `busy`=0, FSM in IDLE.
- **Counter alignment:**
  - `start` high at cycle t means the counter counts during cycles t+1..u, where u is the `stop` cycle.
  - `cnt_i` at t carries none of these increments.
  - `cnt_i` at u+1 carries all of them.
  - Hence `len` = u − t, sampled in SETTLE at u+1.
- **Result latency:** `res_valid` rises at u+2 and is held stable until accepted.
- `res_len` and the statistics are registered outputs, updated at the edge ending SETTLE.
- **Back-to-back runs:**
  - The earliest next accepted `start` is the cycle after the accepting handshake.
  - With `res_ready` tied high, the minimum spacing from `stop` to the next `start` is 3 cycles.
- **Reset mid-run:** the FSM returns to IDLE immediately and the partial run is discarded.

## Structure
- Shared package `clk_counter_pkg` holds:
  - the FSM state enum;
  - default widths CNT_W, SUM_W and NRUN_W;
  - reset constants for min and max.
- One sub-module, `cycle_stats_acc`. It contains min/max/saturating sum/saturating count. Its inputs are `len`, `upd` and `clear`.
- The top level holds the FSM, `base` capture, the subtraction and the result handshake.

## Test plan
- **Single run.** `cnt_i` tracks a behavioural counter. `start` at t=10, `stop` at t=25, `res_ready`=1.
  - `res_valid` at cycle 27 with `res_len`=15.
  - min=max=sum=15, nruns=1.
- **Wrap.** Base `cnt_i`=0xFFFF_FFF0, run length 0x20.
  - `res_len`=0x20.
  - `stat_max`=0x20.
- **Backpressure and missed start.** `res_ready`=0 for 8 cycles after `res_valid` rises, and `start` is pulsed during EMIT.
  - `res_len` is held stable throughout.
  - `missed`=1.
  - The run count is unchanged by the dropped start.
- **Simultaneous strobes.**
  - `start`=`stop`=1 in IDLE: no run, `busy` stays 0.
  - `start`=`stop`=1 in RUN: the run terminates normally with the correct length.
- **Statistics.** Runs of length 5, 40 and 12.
  - min=5, max=40, sum=57, nruns=3.
  - A subsequent `clear` restores all reset values.
- **Reset and saturation.**
  - `rst` asserted mid-RUN: outputs go to reset values asynchronously, and no record is emitted.
  - NRUN_W=2 with 5 runs: `stat_nruns`=3.
